// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit for the execute stage (shift-add multiply, restoring divide).
// Optional: define MULDIV_FAST_MUL_EN to resolve every multiply in one cycle with a combinational multiplier.
module ex_muldiv #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            stall_req,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [127:0] acc, acc_next, mul_next, div_next, fast_raw;
  logic [63:0]  opnd, a_ext, b_ext, sx1, mag1, mag2, special_res, iter_res;
  logic [64:0]  mul_sum, div_shift;
  logic [65:0]  div_diff;
  logic [5:0]   cnt;
  logic [2:0]   r_op;
  logic         r_word, r_neg1, r_neg2;
  logic         is_div, s1_signed, s2_signed, neg1, neg2, div0, ovf, special, fast_mul;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] fin_mul(input logic [127:0] raw, input logic neg,
                                          input logic [1:0] sel, input logic w);
    logic [127:0] p;
    p = neg ? -raw : raw;
    if (w) return sext32(p[31:0]);
    return (sel == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  // Divide state is {remainder, quotient}; word quotients end up in the low 32 bits.
  function automatic logic [63:0] fin_div(input logic [127:0] v, input logic n1, input logic n2,
                                          input logic rem_sel, input logic w);
    logic [63:0] q, r;
    q = w ? {32'b0, v[31:0]} : v[63:0];
    r = v[127:64];
    if (n1 ^ n2) q = -q;
    if (n1) r = -r;
    if (rem_sel) return w ? sext32(r[31:0]) : r;
    return w ? sext32(q[31:0]) : q;
  endfunction

  assign is_div    = op[2];
  assign s1_signed = is_div ? ~op[0] : (op[1:0] != 2'b11);
  assign s2_signed = is_div ? ~op[0] : ~op[1];
  assign sx1       = word ? sext32(src1[31:0]) : src1;
  assign a_ext     = (word && !s1_signed) ? {32'b0, src1[31:0]} : sx1;
  assign b_ext     = word ? (s2_signed ? sext32(src2[31:0]) : {32'b0, src2[31:0]}) : src2;
  assign neg1      = s1_signed & a_ext[63];
  assign neg2      = s2_signed & b_ext[63];
  assign mag1      = neg1 ? -a_ext : a_ext;
  assign mag2      = neg2 ? -b_ext : b_ext;
  assign div0      = (b_ext == 64'd0);
  assign ovf       = ~op[0] & (b_ext == '1) &
                     (word ? (src1[31:0] == 32'h8000_0000) : (src1 == 64'h8000_0000_0000_0000));
  assign special   = is_div & (div0 | ovf);
  assign special_res = div0 ? (op[1] ? sx1 : '1) : (op[1] ? 64'd0 : sx1);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = ~is_div;
  assign fast_raw = {64'b0, mag1} * {64'b0, mag2};
`else
  assign fast_mul = 1'b0;
  assign fast_raw = '0;
`endif

  // One radix-2 step of either algorithm; opnd holds the multiplicand or the divisor magnitude.
  assign mul_sum   = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, opnd} : 65'd0);
  assign mul_next  = {mul_sum, acc[63:1]};
  assign div_shift = {acc[127:64], acc[63]};
  assign div_diff  = {1'b0, div_shift} - {2'b0, opnd};
  assign div_next  = div_diff[65] ? {div_shift[63:0], acc[62:0], 1'b0}
                                  : {div_diff[63:0], acc[62:0], 1'b1};
  assign acc_next  = r_op[2] ? div_next : mul_next;
  assign iter_res  = r_op[2] ? fin_div(acc_next, r_neg1, r_neg2, r_op[1], r_word)
                             : fin_mul(r_word ? {64'b0, acc_next[95:32]} : acc_next,
                                       r_neg1 ^ r_neg2, r_op[1:0], r_word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) state_next = IDLE;
    else begin
      case (state)
        IDLE: if (start) state_next = (special || fast_mul) ? DONE : CALC;
        CALC: if (cnt == 6'd0) state_next = DONE;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req    = start & ~flush & (state != DONE);
    result_valid = (state == DONE);
  end

  // A flush freezes the datapath so result keeps its previous value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0; opnd <= '0; cnt <= '0; r_op <= '0;
      r_word <= 1'b0; r_neg1 <= 1'b0; r_neg2 <= 1'b0; result <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (start) begin
          r_op   <= op;
          r_word <= word;
          r_neg1 <= neg1;
          r_neg2 <= neg2;
          cnt    <= word ? 6'd31 : 6'd63;
          opnd   <= is_div ? mag2 : mag1;
          acc    <= is_div ? {64'b0, (word ? {mag1[31:0], 32'b0} : mag1)} : {64'b0, mag2};
          if (special)       result <= special_res;
          else if (fast_mul) result <= fin_mul(fast_raw, neg1 ^ neg2, op[1:0], word);
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) result <= iter_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv results, latency and stall window
// against a plain-arithmetic RV64M model.
module tb_ex_muldiv;

  logic        clk, rst, start, flush, word, stall_req, result_valid;
  logic [2:0]  op;
  logic [63:0] src1, src2, result, last_result;
  int          checks = 0;
  int          errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  ex_muldiv #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op), .word(word),
    .src1(src1), .src2(src2), .stall_req(stall_req), .result(result),
    .result_valid(result_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ps;
    logic [127:0] pu;
    longint sa, sb;
    int wa, wb;
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; wa = a32; wb = b32;
    r = '0; r32 = '0;
    if (w) begin
      case (o)
        3'b100: if (b32 == 0) r32 = '1; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32; else r32 = wa / wb;
        3'b101: r32 = (b32 == 0) ? '1 : a32 / b32;
        3'b110: if (b32 == 0) r32 = a32; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = 0; else r32 = wa % wb;
        3'b111: r32 = (b32 == 0) ? a32 : a32 % b32;
        default: r32 = a32 * b32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (o)
      3'b000: r = a * b;
      3'b001: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
      3'b010: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); r = ps[127:64]; end
      3'b011: begin pu = {64'b0, a} * {64'b0, b}; r = pu[127:64]; end
      3'b100: if (b == 0) r = '1; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a; else r = sa / sb;
      3'b101: r = (b == 0) ? '1 : a / b;
      3'b110: if (b == 0) r = a; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 0; else r = sa % sb;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Cycles from start to result_valid, which also equals the length of the stall window.
  function automatic int ref_latency(input logic [2:0] o, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    bit zero, over;
    if (o[2]) begin
      zero = w ? (b[31:0] == 0) : (b == 0);
      over = !o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == '1));
      if (zero || over) return 1;
    end else if (FAST) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return {$urandom, 32'hFFFF_FFFF};
      6: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] o, input logic w,
                               input logic [63:0] a, input logic [63:0] b);
    logic [63:0] exp;
    int lat, k, stalls;
    bit timed_out;
    exp = ref_result(o, w, a, b);
    lat = ref_latency(o, w, a, b);
    @(negedge clk);
    op = o; word = w; src1 = a; src2 = b; start = 1'b1;
    k = 0; stalls = 0; timed_out = 1'b0;
    #1;
    while (!result_valid) begin
      if (stall_req) stalls++;
      if (k >= 200) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput({tag, " timeout"}, 64'(timed_out), 64'd0);
    checkOutput({tag, " result"}, result, exp);
    checkOutput({tag, " latency"}, 64'(k), 64'(lat));
    checkOutput({tag, " stall cycles"}, 64'(stalls), 64'(lat));
    checkOutput({tag, " stall in done"}, 64'(stall_req), 64'd0);
    start = 1'b0;
    last_result = exp;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; word = 1'b0;
    src1 = '0; src2 = '0; last_result = '0;
    @(negedge clk);
    #1;
    checkOutput("reset result", result, 64'd0);
    checkOutput("reset valid", 64'(result_valid), 64'd0);
    checkOutput("reset stall", 64'(stall_req), 64'd0);
    rst = 1'b1;

    applyStimulus("mul 7*-3", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus("mulhu", 3'b011, 1'b0, '1, '1);
    applyStimulus("mulhsu", 3'b010, 1'b0, '1, 64'd2);
    applyStimulus("div by zero", 3'b100, 1'b0, 64'h1234, 64'd0);
    applyStimulus("rem by zero", 3'b110, 1'b0, 64'h1234, 64'd0);
    applyStimulus("div overflow", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1);
    applyStimulus("remw overflow", 3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
    applyStimulus("divw -7/2", 3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    applyStimulus("remw -7/2", 3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);

    @(negedge clk);
    #1;
    checkOutput("hold valid", 64'(result_valid), 64'd0);
    checkOutput("hold result", result, last_result);

    applyStimulus("divu 100/7", 3'b101, 1'b0, 64'd100, 64'd7);
    applyStimulus("divu 9/3", 3'b101, 1'b0, 64'd9, 64'd3);

    // Flush ten cycles into a divide: no result, result register untouched.
    @(negedge clk);
    op = 3'b100; word = 1'b0; src1 = 64'd1000; src2 = 64'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("flush stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    checkOutput("flush valid", 64'(result_valid), 64'd0);
    checkOutput("flush result", result, last_result);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("flush idle valid", 64'(result_valid), 64'd0);
    applyStimulus("after flush", 3'b111, 1'b0, 64'd1000, 64'd3);

    // Reset pulse in the middle of a multiply.
    @(negedge clk);
    op = 3'b000; word = 1'b0; src1 = 64'd5; src2 = 64'd6; start = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midreset result", result, 64'd0);
    checkOutput("midreset valid", 64'(result_valid), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus("after reset", 3'b000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd6);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      logic rw;
      logic [63:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ra = pick_operand();
      rb = pick_operand();
      applyStimulus($sformatf("rand%0d op=%0d w=%0d", i, ro, rw), ro, rw, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
